slt_serial_32: RTL and testbench
================================

Name: slt_serial_32

Overview:
- Multi-cycle, bit-serial set-less-than unit: the iterative counterpart of the combinational slt_32, for area-constrained ALU builds.
- Accepts two operands on a start/done handshake and computes A - B one bit per cycle, LSB first, using a single full-adder slice and a carry flop.
- Returns the MIPS-style SLT/SLTU result word: 32'b1 if A < B, else 32'b0.
- Sits beside the ALU and is driven by the multi-cycle control unit.

Parameters:
- WIDTH, 32: operand and result width; must be at least 2.
- CNT_W, 5: bit-counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- is_signed  input  1  1 = SLT (two's complement), 0 = SLTU; latched with the operands.
- A  input  WIDTH  first operand; latched on an accepted start.
- B  input  WIDTH  second operand; latched on an accepted start.
- busy  output  1  high in RUN and FIN states.
- done  output  1  one-cycle pulse in FIN, when R is valid.
- R  output  WIDTH  result, {WIDTH-1 zeros, lt}.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE, busy=0, done=0, R=0.
  - Internal A/B shift registers, sign flag, carry and counter cleared.
- States: IDLE -> RUN -> FIN -> IDLE.
- IDLE:
  - On a rising edge with start=1: latch A, B and is_signed; set carry=1 (computing A + ~B + 1); set cnt=0; go to RUN.
  - start=0: stay in IDLE. R holds its last value.
- RUN, one bit per cycle:
  - s = a0 ^ ~b0 ^ carry; carry <= majority(a0, ~b0, carry).
  - Shift both operand registers right by one; cnt <= cnt+1.
  - On bit WIDTH-1, capture sum bit s_msb, carry-in c_in and carry-out c_out. Go to FIN after cnt reaches WIDTH-1.
- FIN, exactly one cycle:
  - done=1 and busy=1.
  - Signed: lt = s_msb ^ (c_in ^ c_out), i.e. sign XOR overflow.
  - Unsigned: lt = ~c_out.
  - R <= {0, lt}, written on the edge entering FIN, so R is valid while done=1.
  - Next state is IDLE.
- Latency:
  - start sampled at edge k gives done=1 during the cycle after edge k+WIDTH+... precisely, FIN is entered at edge k+WIDTH.
  - done is high from edge k+WIDTH to edge k+WIDTH+1.
  - The next start is accepted at edge k+WIDTH+1 at the earliest.
- start while busy (RUN or FIN): ignored; operands are not re-latched and in-flight data is not disturbed.
- Changes on A/B/is_signed after acceptance: no effect on the current operation.
- A == B: lt=0 for both modes.
- Most-negative operand (0x80000000) must be handled correctly via the overflow term; there is no special case.
- R holds across IDLE until the next FIN; it is not cleared by start.
- Reset mid-operation: immediate return to IDLE with outputs zeroed. No done is emitted for the aborted operation.
- No combinational path from inputs to outputs; busy, done and R are all registered.

Test Plan:
- A=7, B=32, is_signed=1, start pulse -> done exactly 33 cycles after the start edge (WIDTH+1); R=32'h00000001; busy high for 33 cycles.
- A=5, B=32'hFFFFFFFD (-3): signed -> R=0; repeated with is_signed=0 -> R=1 (5 < 4294967293).
- A=-4 (32'hFFFFFFFC), B=-3 -> R=1; swapped operands -> R=0; A=B=15 -> R=0 in both modes.
- A=32'h80000000, B=1, signed -> R=1; unsigned -> R=0. A=32'h7FFFFFFF, B=32'h80000000, signed -> R=0 (overflow path).
- start re-pulsed with different A/B at cycle 10 of RUN -> ignored; R matches the first operands; done pulses exactly once.
- rst_n driven low at cycle 15 of RUN -> busy, done and R are 0 at once with no clock edge needed. A fresh start after release completes normally with the correct R.

Source files
------------

// File: rtl/slt_serial_32_if.sv
// Operand/result bundle for the bit-serial set-less-than unit.
// The control unit holds the master side; the unit itself takes the slave side.
interface slt_serial_32_if #(
    parameter int WIDTH = 32
);
    // start is a request pulse, honoured only while busy=0. The operands and
    // is_signed are captured on that same edge. done pulses for exactly one
    // cycle, and R is valid during that cycle. R then holds its value until
    // the next done.
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] R;
    logic [1:0]       state_dbg;

    modport master (
        output start, is_signed, A, B,
        input  busy, done, R, state_dbg
    );

    modport slave (
        input  start, is_signed, A, B,
        output busy, done, R, state_dbg
    );
endinterface

// File: rtl/slt_serial_32.sv
// Bit-serial SLT/SLTU. It forms A + ~B + 1 one bit per cycle, LSB first,
// using a single full-adder slice and a carry flop.
module slt_serial_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    slt_serial_32_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_q;
    logic             sgn_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic a0;
    logic nb0;
    logic s;
    logic c_out;
    logic last;
    logic lt;

    // Full-adder slice. On the final bit, carry is the carry into the MSB,
    // so sum ^ (c_in ^ c_out) gives the sign corrected for overflow.
    always_comb begin
        a0    = a_sh[0];
        nb0   = ~b_sh[0];
        s     = a0 ^ nb0 ^ carry;
        c_out = (a0 & nb0) | (a0 & carry) | (nb0 & carry);
        last  = (cnt == CNT_W'(WIDTH - 1));
        lt    = sgn_q ? (s ^ carry ^ c_out) : ~c_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            r_q   <= '0;
            sgn_q <= 1'b0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.A;
                        b_sh  <= bus.B;
                        sgn_q <= bus.is_signed;
                        carry <= 1'b1;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= c_out;
                    cnt   <= cnt + CNT_W'(1);
                    // The result is written on the edge that enters FIN, so
                    // R is already valid while done is high.
                    if (last) begin
                        r_q <= {{(WIDTH-1){1'b0}}, lt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == RUN) || (state == FIN);
    assign bus.done      = (state == FIN);
    assign bus.R         = r_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_slt_serial_32.sv
// Directed bench for slt_serial_32. A scoreboard queue holds the expected
// result words, which are compared when done pulses.
module tb_slt_serial_32;
    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    slt_serial_32_if #(.WIDTH(W)) bus ();

    slt_serial_32 #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int             tests = 0;
    int             fails = 0;
    logic [W-1:0]   exp_q[$];
    logic [W-1:0]   last_r = '0;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sgn);
        logic lt;
        if (sgn) lt = ($signed(a) < $signed(b));
        else     lt = (a < b);
        return {{(W-1){1'b0}}, lt};
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one operation. If pulse_at is nonzero, a second start carrying
    // different operands is driven on that cycle of RUN.
    task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, input int pulse_at);
        int           cyc;
        int           busy_cnt;
        int           done_cnt;
        int           done_cyc;
        logic [W-1:0] got;
        logic [W-1:0] exp;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.is_signed = sgn; bus.start = 1'b1;
        exp_q.push_back(model(a, b, sgn));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.A = $urandom; bus.B = $urandom; bus.is_signed = ~sgn;
        cyc = 0; busy_cnt = 0; done_cnt = 0; done_cyc = 0; got = '0;
        while (cyc < 3 * W) begin
            @(negedge clk);
            cyc++;
            if (bus.start) bus.start = 1'b0;
            if (pulse_at != 0 && cyc == pulse_at) begin
                bus.A = ~a; bus.B = ~b; bus.is_signed = ~sgn; bus.start = 1'b1;
            end
            if (cyc == 1) check({tag, " r_hold"}, bus.R, last_r);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = cyc;
                    got = bus.R;
                end
            end
            if (done_cyc != 0 && cyc >= done_cyc + 3) break;
        end
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " latency"}, done_cyc, W + 1);
        check({tag, " busy_cycles"}, busy_cnt, W + 1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check({tag, " result"}, got, exp);
            last_r = exp;
        end
    endtask

    logic [W-1:0] ta [10] = '{32'd7, 32'd5, 32'd5, 32'hFFFFFFFC, 32'hFFFFFFFD,
                              32'd15, 32'd15, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [W-1:0] tb [10] = '{32'd32, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFC,
                              32'd15, 32'd15, 32'd1, 32'd1, 32'h80000000};
    logic         ts [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.A = '0; bus.B = '0;

        repeat (2) @(negedge clk);
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset R", bus.R, 0);
        check("reset state", bus.state_dbg, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle busy", bus.busy, 0);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("dir%0d", i), ta[i], tb[i], ts[i], 0);
        end

        for (int i = 0; i < 4; i++) begin
            do_op($sformatf("rnd%0d", i), $urandom, $urandom, 1'($urandom_range(0, 1)), 0);
        end

        do_op("lt_7_32_a", 32'd7, 32'd32, 1'b1, 0);
        do_op("ignore_restart", 32'd7, 32'd32, 1'b1, 10);

        // Abort mid-RUN. R still holds 1 from the previous operation.
        @(negedge clk);
        bus.A = 32'd100; bus.B = 32'd3; bus.is_signed = 1'b1; bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);
        check("abort busy_before", bus.busy, 1);
        check("abort r_before", bus.R, last_r);
        rst_n = 1'b0;
        #1;
        check("abort busy", bus.busy, 0);
        check("abort done", bus.done, 0);
        check("abort R", bus.R, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_r = '0;
        do_op("after_reset", 32'hFFFFFFFC, 32'hFFFFFFFD, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
